token_dispatcher: RTL and testbench
===================================

Name: token_dispatcher

Overview:
- Sits between the preparser's slice queue and NUM_LANES parallel second-level token parsers.
- Pops one slice at a time from the queue and hands it to parser lanes in strict round-robin order: slice k always goes to lane k mod NUM_LANES.
- Each slice is tagged with a sequence number so the downstream merger can restore stream order.
- Provides stream-drain status and a dispatch counter.

Parameters:
- NUM_LANES, 4, number of parser lanes (1..16).
- PAY_W, 181, slice payload width {data 144, position 16, address 17, garbage 3, lit_flag 1}.
- SEQ_W, 16, sequence-number and dispatch-counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  permits fetching new slices.
- q_valid  in  1  queue head holds a valid slice.
- q_empty  in  1  queue storage empty.
- q_data  in  PAY_W  queue head payload.
- q_rdreq  out  1  pop queue head.
- lane_idle  in  NUM_LANES  lane i ready to accept a slice.
- lane_start  out  NUM_LANES  one-hot, one-cycle start pulse.
- slice_data  out  PAY_W  payload broadcast to all lanes.
- slice_seq  out  SEQ_W  sequence number of the slice in slice_data.
- lane_ptr  out  log2(NUM_LANES), min 1  next lane to be served.
- dispatch_cnt  out  SEQ_W  total slices dispatched.
- all_done  out  1  pipeline drained.

Behaviour:
- Reset values (all outputs): state=S_IDLE, lane_start=0, slice_data=0, slice_seq=0, lane_ptr=0, dispatch_cnt=0, q_rdreq=0.
  - all_done after reset equals q_empty & ~q_valid & (&lane_idle).
- A reset asserted mid-operation aborts any held slice without issuing it and returns to S_IDLE.
- FSM S_IDLE:
  - q_rdreq = q_valid & enable & rst_n, combinational from the current state.
  - On a clock edge with q_rdreq=1: slice_data <= q_data, go to S_WAIT_LANE.
  - Otherwise remain in S_IDLE.
- FSM S_WAIT_LANE:
  - q_rdreq=0.
  - On an edge with lane_idle[lane_ptr]=1:
    - lane_start <= onehot(lane_ptr) for exactly one cycle.
    - slice_seq <= dispatch_cnt.
    - dispatch_cnt <= dispatch_cnt+1, wrapping mod 2^SEQ_W.
    - lane_ptr <= lane_ptr+1, wrapping from NUM_LANES-1 to 0.
    - Go to S_GAP.
  - Otherwise hold. Never skip to another idle lane; strict order is mandatory.
- FSM S_GAP:
  - Unconditionally go to S_IDLE.
  - This state covers the queue's one-cycle head/valid update after a pop.
  - It also guarantees lane_idle is re-sampled at least 2 cycles after lane_start, which makes NUM_LANES=1 safe.
- lane_start is a registered output, zero in every cycle except the one following a dispatch edge.
- Lane contract:
  - A lane samples slice_data and slice_seq in the cycle lane_start is high.
  - The lane drops lane_idle by the next edge.
  - slice_data stays stable from capture until the next capture.
- enable is sampled only in S_IDLE. Deasserting it never aborts a captured slice; that slice is still dispatched.
- Throughput is 1 slice per 3 cycles.
- Latency: q_valid seen in S_IDLE at edge e0 → lane_start high during cycle e1..e2, provided the target lane is idle.
- all_done = (state==S_IDLE) & q_empty & ~q_valid & (&lane_idle), combinational.
- q_data is ignored whenever q_rdreq=0.
- Back-pressure from the queue is not possible: q_rdreq is only raised with q_valid=1.

Test Plan:
- NUM_LANES=4, all lanes idle, 5 slices queued with data 0x1..0x5 → lane_start sequence 0001, 0010, 0100, 1000, 0001 with slice_seq 0..4 and matching slice_data; dispatch_cnt=5; pulses spaced 3 cycles apart.
- Lane 1 lane_idle held low for 20 cycles after slice 0 → FSM holds in S_WAIT_LANE; no lane_start pulse to lanes 2/3 during the wait; slice 1 issues to lane 1 on the edge after lane_idle[1] rises; q_rdreq stays 0 while waiting.
- Queue empty with enable=1 → q_rdreq=0, no lane_start; all_done=1 when every lane is idle; all_done=0 while any lane is busy.
- enable dropped in the cycle after a capture → captured slice is still dispatched; no further q_rdreq until enable=1.
- Reset asserted during S_WAIT_LANE → next cycle lane_start=0, lane_ptr=0, dispatch_cnt=0, state S_IDLE; the first slice after reset goes to lane 0 with seq 0.
- NUM_LANES=1, SEQ_W=4, 18 back-to-back slices; lane drops lane_idle the cycle after start and raises it 2 cycles later → all issue to lane 0, slice_seq wraps 15→0, no double start.

Source files
------------

// File: rtl/token_dispatcher.sv
// token_dispatcher
//
// Takes slices one at a time from the preparser's slice queue and hands them to
// NUM_LANES second-level token parsers in strict round-robin order. Slice k
// always goes to lane k mod NUM_LANES and carries sequence number
// k mod 2^SEQ_W so the downstream merger can restore stream order.
//
// Ports
//   clk           clock
//   rst_n         synchronous, active-low reset
//   enable        permits fetching new slices (sampled only while idle)
//   q_valid       queue head holds a valid slice
//   q_empty       queue storage empty
//   q_data        queue head payload
//   q_rdreq       pop queue head (combinational)
//   lane_idle     per-lane ready to accept a slice
//   lane_start    one-hot, one-cycle start pulse to the served lane
//   slice_data    payload broadcast to all lanes
//   slice_seq     sequence number of the slice in slice_data
//   lane_ptr      next lane to be served
//   dispatch_cnt  total slices dispatched (wraps)
//   all_done      idle, queue drained and every lane idle (combinational)
module token_dispatcher #(
  parameter int NUM_LANES = 4,
  parameter int PAY_W     = 181,
  parameter int SEQ_W     = 16,
  localparam int PTR_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 q_valid,
  input  logic                 q_empty,
  input  logic [PAY_W-1:0]     q_data,
  output logic                 q_rdreq,
  input  logic [NUM_LANES-1:0] lane_idle,
  output logic [NUM_LANES-1:0] lane_start,
  output logic [PAY_W-1:0]     slice_data,
  output logic [SEQ_W-1:0]     slice_seq,
  output logic [PTR_W-1:0]     lane_ptr,
  output logic [SEQ_W-1:0]     dispatch_cnt,
  output logic                 all_done
);

  // S_GAP gives the queue one cycle to update its head after a pop and keeps
  // lane_idle from being re-sampled earlier than 2 cycles after lane_start,
  // which is what makes a single-lane configuration safe.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LANE = 2'd1,
    S_GAP       = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nx_s;
  logic [NUM_LANES-1:0]   ptr_onehot_s;
  logic                   target_idle_s;
  logic [PTR_W-1:0]       ptr_next_s;
  logic                   capture_s;
  logic                   dispatch_s;

  // Decode the lane pointer to a one-hot lane mask.
  always_comb begin
    ptr_onehot_s = {NUM_LANES{1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_ptr == PTR_W'(i)) begin
        ptr_onehot_s[i] = 1'b1;
      end else begin
        ptr_onehot_s[i] = 1'b0;
      end
    end
  end

  // Only the lane whose turn it is may take the slice; other idle lanes are ignored.
  assign target_idle_s = |(lane_idle & ptr_onehot_s);

  // Round-robin successor of the lane pointer.
  always_comb begin
    if (lane_ptr == PTR_W'(NUM_LANES - 1)) begin
      ptr_next_s = {PTR_W{1'b0}};
    end else begin
      ptr_next_s = lane_ptr + PTR_W'(1);
    end
  end

  // Next-state logic and the combinational pop request.
  always_comb begin
    state_nx_s = state_r;
    q_rdreq    = 1'b0;
    capture_s  = 1'b0;
    dispatch_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        // rst_n is folded in so the queue is never popped on a reset edge.
        q_rdreq = q_valid & enable & rst_n;
        if (q_valid & enable & rst_n) begin
          capture_s  = 1'b1;
          state_nx_s = S_WAIT_LANE;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_WAIT_LANE: begin
        if (target_idle_s) begin
          dispatch_s = 1'b1;
          state_nx_s = S_GAP;
        end else begin
          state_nx_s = S_WAIT_LANE;
        end
      end
      S_GAP: begin
        state_nx_s = S_IDLE;
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // State register and registered lane-facing outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      lane_start   <= {NUM_LANES{1'b0}};
      slice_data   <= {PAY_W{1'b0}};
      slice_seq    <= {SEQ_W{1'b0}};
      lane_ptr     <= {PTR_W{1'b0}};
      dispatch_cnt <= {SEQ_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      if (dispatch_s) begin
        lane_start   <= ptr_onehot_s;
        slice_seq    <= dispatch_cnt;
        dispatch_cnt <= dispatch_cnt + SEQ_W'(1);
        lane_ptr     <= ptr_next_s;
      end else begin
        lane_start   <= {NUM_LANES{1'b0}};
      end
      // slice_data holds from one capture to the next so lanes may sample late.
      if (capture_s) begin
        slice_data <= q_data;
      end else begin
        slice_data <= slice_data;
      end
    end
  end

  assign all_done = (state_r == S_IDLE) & q_empty & ~q_valid & (&lane_idle);

endmodule

// File: tb/tb_token_dispatcher.sv
// Bench for token_dispatcher: a 4-lane/16-bit-seq instance and a 1-lane/4-bit-seq
// instance run side by side against a transaction-level reference model.
module tb_token_dispatcher;
  localparam int PAY_W = 181;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             enable    [2];
  logic             q_valid   [2];
  logic             q_empty   [2];
  logic [PAY_W-1:0] q_data    [2];
  logic [15:0]      lane_idle [2];

  logic             rdreq0, rdreq1, done0, done1;
  logic [3:0]       ls0;
  logic             ls1;
  logic [PAY_W-1:0] sd0, sd1;
  logic [15:0]      seq0, cnt0;
  logic [3:0]       seq1, cnt1;
  logic [1:0]       ptr0;
  logic             ptr1;

  token_dispatcher #(.NUM_LANES(4), .PAY_W(PAY_W), .SEQ_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable[0]), .q_valid(q_valid[0]),
    .q_empty(q_empty[0]), .q_data(q_data[0]), .q_rdreq(rdreq0),
    .lane_idle(lane_idle[0][3:0]), .lane_start(ls0), .slice_data(sd0),
    .slice_seq(seq0), .lane_ptr(ptr0), .dispatch_cnt(cnt0), .all_done(done0));

  token_dispatcher #(.NUM_LANES(1), .PAY_W(PAY_W), .SEQ_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable[1]), .q_valid(q_valid[1]),
    .q_empty(q_empty[1]), .q_data(q_data[1]), .q_rdreq(rdreq1),
    .lane_idle(lane_idle[1][0:0]), .lane_start(ls1), .slice_data(sd1),
    .slice_seq(seq1), .lane_ptr(ptr1), .dispatch_cnt(cnt1), .all_done(done1));

  function automatic logic [15:0] o_start(int d);
    return (d == 0) ? {12'd0, ls0} : {15'd0, ls1};
  endfunction
  function automatic logic [PAY_W-1:0] o_data(int d);
    return (d == 0) ? sd0 : sd1;
  endfunction
  function automatic logic [15:0] o_seq(int d);
    return (d == 0) ? seq0 : {12'd0, seq1};
  endfunction
  function automatic logic [15:0] o_ptr(int d);
    return (d == 0) ? {14'd0, ptr0} : {15'd0, ptr1};
  endfunction
  function automatic logic [15:0] o_cnt(int d);
    return (d == 0) ? cnt0 : {12'd0, cnt1};
  endfunction
  function automatic logic o_rdreq(int d);
    return (d == 0) ? rdreq0 : rdreq1;
  endfunction
  function automatic logic o_done(int d);
    return (d == 0) ? done0 : done1;
  endfunction

  // Source queues feeding each instance.
  logic [PAY_W-1:0] src0[$];
  logic [PAY_W-1:0] src1[$];
  function automatic int src_size(int d);
    return (d == 0) ? src0.size() : src1.size();
  endfunction
  function automatic logic [PAY_W-1:0] src_head(int d);
    if (src_size(d) == 0) return '0;
    return (d == 0) ? src0[0] : src1[0];
  endfunction
  task automatic src_pop(int d);
    if (d == 0) void'(src0.pop_front()); else void'(src1.pop_front());
  endtask
  task automatic src_push(int d, logic [PAY_W-1:0] v);
    if (d == 0) src0.push_back(v); else src1.push_back(v);
  endtask

  function automatic logic [PAY_W-1:0] rand_pay();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[PAY_W-1:0];
  endfunction

  // Reference model: a slice is either pending (captured, awaiting its lane),
  // in the one-cycle post-dispatch gap, or the block is free to pop.
  int          nl   [2] = '{4, 1};
  int unsigned mask [2] = '{32'hFFFF, 32'hF};
  bit          m_pend [2];
  bit          m_cool [2];
  bit          popped [2];
  int unsigned m_cnt  [2];
  logic [PAY_W-1:0] e_data [2];
  logic [15:0] e_start [2], e_seq [2], e_cnt [2], e_ptr [2];

  // Environment controls.
  int   busy [2][16];
  logic [15:0] hold [2];
  bit   en [2];
  bit   drop_after_pop [2];
  bit   rst_req;
  int   extra_max;
  int   cyc, checks, errors;

  // Dispatch log, used by the hand-computed checks.
  int               lg_n     [2];
  logic [15:0]      lg_start [2][64];
  logic [15:0]      lg_seq   [2][64];
  logic [PAY_W-1:0] lg_data  [2][64];
  int               lg_cyc   [2][64];

  task automatic chk(string name, int d, logic [PAY_W-1:0] act, logic [PAY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h want %0h", name, d, cyc, act, exp);
    end
  endtask

  // One clock cycle: compare registered outputs, react as lanes/queue, drive
  // inputs, compare combinational outputs, then advance the model over the edge.
  task automatic cycle();
    logic [15:0] st;
    bit exp_rd, exp_done, all_idle;
    int p;
    cyc++;
    @(negedge clk);
    rst_n = rst_req;
    for (int d = 0; d < 2; d++) begin
      st = o_start(d);
      chk("lane_start",   d, st,        e_start[d]);
      chk("slice_data",   d, o_data(d), e_data[d]);
      chk("slice_seq",    d, o_seq(d),  e_seq[d]);
      chk("lane_ptr",     d, o_ptr(d),  e_ptr[d]);
      chk("dispatch_cnt", d, o_cnt(d),  e_cnt[d]);
      if (st != 16'd0 && lg_n[d] < 64) begin
        lg_start[d][lg_n[d]] = st;
        lg_seq[d][lg_n[d]]   = o_seq(d);
        lg_data[d][lg_n[d]]  = o_data(d);
        lg_cyc[d][lg_n[d]]   = cyc;
        lg_n[d]++;
      end
      for (int i = 0; i < nl[d]; i++)
        if (st[i]) busy[d][i] = 2 + ((extra_max > 0) ? $urandom_range(0, extra_max) : 0);
      lane_idle[d] = 16'd0;
      for (int i = 0; i < nl[d]; i++) begin
        lane_idle[d][i] = (busy[d][i] == 0) && !hold[d][i];
        if (busy[d][i] > 0) busy[d][i]--;
      end
      if (drop_after_pop[d] && popped[d]) en[d] = 1'b0;
      enable[d]  = en[d];
      q_valid[d] = (src_size(d) > 0);
      q_empty[d] = (src_size(d) <= 1);
      q_data[d]  = q_valid[d] ? src_head(d) : rand_pay();
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      all_idle = 1'b1;
      for (int i = 0; i < nl[d]; i++) all_idle &= lane_idle[d][i];
      exp_rd   = rst_n && !m_pend[d] && !m_cool[d] && q_valid[d] && enable[d];
      exp_done = !m_pend[d] && !m_cool[d] && q_empty[d] && !q_valid[d] && all_idle;
      chk("q_rdreq",  d, o_rdreq(d), exp_rd);
      chk("all_done", d, o_done(d),  exp_done);
      popped[d]  = 1'b0;
      e_start[d] = 16'd0;
      if (!rst_n) begin
        m_pend[d] = 1'b0; m_cool[d] = 1'b0; m_cnt[d] = 0;
        e_data[d] = '0;   e_seq[d] = 16'd0;
      end else if (m_cool[d]) begin
        m_cool[d] = 1'b0;
      end else if (m_pend[d]) begin
        p = int'(m_cnt[d] % nl[d]);
        if (lane_idle[d][p]) begin
          e_start[d] = 16'd1 << p;
          e_seq[d]   = 16'(m_cnt[d] & mask[d]);
          m_cnt[d]++;
          m_pend[d]  = 1'b0;
          m_cool[d]  = 1'b1;
        end
      end else if (exp_rd) begin
        e_data[d] = q_data[d];
        m_pend[d] = 1'b1;
        popped[d] = 1'b1;
        src_pop(d);
      end
      e_cnt[d] = 16'(m_cnt[d] & mask[d]);
      e_ptr[d] = 16'(m_cnt[d] % nl[d]);
    end
  endtask

  task automatic do_reset(int n);
    rst_req = 1'b0;
    repeat (n) cycle();
    rst_req = 1'b1;
  endtask

  task automatic clear_logs();
    lg_n[0] = 0;
    lg_n[1] = 0;
  endtask

  logic [15:0] exp_a [5] = '{16'h1, 16'h2, 16'h4, 16'h8, 16'h1};
  logic [15:0] cnt_before;
  int rel_cyc;

  initial begin
    rst_n = 1'b0; rst_req = 1'b0; extra_max = 0; cyc = 0; checks = 0; errors = 0;
    for (int d = 0; d < 2; d++) begin
      enable[d] = 1'b0; q_valid[d] = 1'b0; q_empty[d] = 1'b1; q_data[d] = '0;
      lane_idle[d] = 16'd0; hold[d] = 16'd0; en[d] = 1'b1; drop_after_pop[d] = 1'b0;
      m_pend[d] = 1'b0; m_cool[d] = 1'b0; popped[d] = 1'b0; m_cnt[d] = 0;
      e_data[d] = '0; e_start[d] = 16'd0; e_seq[d] = 16'd0; e_cnt[d] = 16'd0; e_ptr[d] = 16'd0;
      for (int i = 0; i < 16; i++) busy[d][i] = 0;
    end
    clear_logs();

    // A: five slices 1..5, all lanes idle.
    do_reset(2);
    chk("A_reset_cnt", 0, o_cnt(0), 16'd0);
    chk("A_reset_ptr", 0, o_ptr(0), 16'd0);
    for (int k = 1; k <= 5; k++) begin
      src_push(0, PAY_W'(k));
      src_push(1, PAY_W'(k));
    end
    repeat (20) cycle();
    chk("A_count", 0, lg_n[0], 5);
    for (int k = 0; k < 5; k++) begin
      chk("A_onehot", 0, lg_start[0][k], exp_a[k]);
      chk("A_seq",    0, lg_seq[0][k], k);
      chk("A_data",   0, lg_data[0][k], k + 1);
      if (k > 0) chk("A_spacing", 0, lg_cyc[0][k] - lg_cyc[0][k-1], 3);
    end
    chk("A_cnt", 0, o_cnt(0), 16'd5);

    // B: lane 1 stalls; strict order means nothing else goes out meanwhile.
    do_reset(1);
    clear_logs();
    hold[0] = 16'h0002;
    for (int k = 0; k < 3; k++) begin
      src_push(0, rand_pay());
      src_push(1, rand_pay());
    end
    repeat (25) cycle();
    chk("B_held_pulses", 0, lg_n[0], 1);
    chk("B_first_lane",  0, lg_start[0][0], 16'h1);
    rel_cyc = cyc + 1;
    hold[0] = 16'h0000;
    repeat (10) cycle();
    chk("B_total",     0, lg_n[0], 3);
    chk("B_lane1",     0, lg_start[0][1], 16'h2);
    chk("B_lane1_seq", 0, lg_seq[0][1], 16'd1);
    chk("B_release",   0, lg_cyc[0][1], rel_cyc + 1);

    // C: drained queue, all_done tracks lane activity.
    repeat (5) cycle();
    chk("C_done_idle",  0, o_done(0), 1'b1);
    chk("C_no_rdreq",   0, o_rdreq(0), 1'b0);
    hold[0] = 16'h0004;
    cycle();
    chk("C_done_busy",  0, o_done(0), 1'b0);
    hold[0] = 16'h0000;
    cycle();
    chk("C_done_again", 0, o_done(0), 1'b1);

    // D: enable dropped right after a capture.
    cnt_before = o_cnt(0);
    drop_after_pop[0] = 1'b1; drop_after_pop[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      src_push(0, rand_pay());
      src_push(1, rand_pay());
    end
    repeat (15) cycle();
    chk("D_one_dispatch", 0, o_cnt(0), 16'(cnt_before + 16'd1));
    chk("D_left_queued",  0, src_size(0), 1);
    drop_after_pop[0] = 1'b0; drop_after_pop[1] = 1'b0;
    en[0] = 1'b1; en[1] = 1'b1;
    repeat (12) cycle();
    chk("D_resumed", 0, o_cnt(0), 16'(cnt_before + 16'd2));

    // E: reset while a slice waits for its lane.
    hold[0] = 16'h000F;
    src_push(0, rand_pay());
    src_push(1, rand_pay());
    repeat (5) cycle();
    rst_req = 1'b0;
    cycle();
    rst_req = 1'b1;
    hold[0] = 16'h0000;
    cycle();
    chk("E_start", 0, o_start(0), 16'd0);
    chk("E_ptr",   0, o_ptr(0), 16'd0);
    chk("E_cnt",   0, o_cnt(0), 16'd0);
    clear_logs();
    src_push(0, PAY_W'(12'hABC));
    src_push(1, PAY_W'(12'hABC));
    repeat (8) cycle();
    chk("E_lane0", 0, lg_start[0][0], 16'h1);
    chk("E_seq0",  0, lg_seq[0][0], 16'd0);
    chk("E_data",  0, lg_data[0][0], PAY_W'(12'hABC));

    // F: 18 back-to-back slices; the single-lane instance wraps its 4-bit seq.
    do_reset(1);
    clear_logs();
    for (int k = 0; k < 18; k++) begin
      src_push(0, PAY_W'(256 + k));
      src_push(1, PAY_W'(256 + k));
    end
    repeat (70) cycle();
    chk("F_count", 1, lg_n[1], 18);
    for (int k = 0; k < 18; k++) begin
      chk("F_lane", 1, lg_start[1][k], 16'h1);
      chk("F_seq",  1, lg_seq[1][k], k % 16);
      chk("F_data", 1, lg_data[1][k], 256 + k);
      if (k > 0) chk("F_spacing", 1, lg_cyc[1][k] - lg_cyc[1][k-1], 3);
    end
    chk("F_cnt_wrap", 1, o_cnt(1), 16'd2);

    // G: randomized traffic, stalls, enable toggling and occasional resets.
    extra_max = 4;
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 2) == 0 && src_size(d) < 6) src_push(d, rand_pay());
        en[d]   = ($urandom_range(0, 7) != 0);
        hold[d] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'h0000;
      end
      rst_req = ($urandom_range(0, 499) != 0);
      cycle();
    end
    rst_req = 1'b1;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b1;
      hold[d] = 16'h0000;
    end
    repeat (60) cycle();
    chk("G_drained", 0, o_done(0), 1'b1);
    chk("G_drained", 1, o_done(1), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
